// File: rtl/demux4_dispatch_ctrl.sv
// 1:4 dispatch controller: holds one accepted word and offers it to one channel,
// chosen by explicit select or round-robin, with delivery timeout and per-channel counters.
module demux4_dispatch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [1:0]           in_sel,
  input  logic                 mode,
  input  logic [3:0]           ch_en,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy,
  output logic                 drop,
  input  logic                 cnt_clr,
  output logic [4*CNT_W-1:0]   cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [3:0]          out_valid_q, out_valid_d;
  logic                drop_q, drop_d;
  logic [1:0]          rr_pick;
  logic [1:0]          new_tgt;
  logic                accept;
  logic                deliver;
  logic                timeout;

  // Descending scan so the smallest offset from rr_ptr wins; 2-bit add wraps 3 -> 0.
  always_comb begin
    rr_pick = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (ch_en[rr_ptr_q + 2'(i)]) rr_pick = rr_ptr_q + 2'(i);
    end
  end

  assign in_ready = !rst && (state_q == IDLE) && (!mode || (ch_en != 4'b0000));
  assign accept   = in_valid && in_ready;
  assign new_tgt  = mode ? rr_pick : in_sel;
  assign deliver  = (state_q == BUSY) && out_ready[tgt_q];
  assign timeout  = (TIMEOUT != 0) && (state_q == BUSY) && !out_ready[tgt_q] &&
                    (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tgt_d       = tgt_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    drop_d      = timeout;
    if (accept) begin
      state_d     = BUSY;
      hold_d      = in_data;
      tgt_d       = new_tgt;
      wait_d      = '0;
      out_valid_d = 4'b0001 << new_tgt;
    end else if (deliver || timeout) begin
      state_d     = IDLE;
      wait_d      = '0;
      out_valid_d = 4'b0000;
      if (mode) rr_ptr_d = tgt_q + 2'd1;
    end else if (state_q == BUSY) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      tgt_q       <= 2'd0;
      wait_q      <= '0;
      hold_q      <= '0;
      out_valid_q <= 4'b0000;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      tgt_q       <= tgt_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = hold_q;
  assign busy      = (state_q == BUSY);
  assign drop      = drop_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Clear takes priority over a same-cycle delivery.
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
          cnt_d = '0;
        end else if (deliver && (tgt_q == 2'(gi)) && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end
  endgenerate

endmodule

// File: tb/tb_demux4_dispatch_ctrl.sv
// Bench for demux4_dispatch_ctrl: directed scenarios plus randomized traffic, all
// compared each cycle against a word-level reference model.
module tb_demux4_dispatch_ctrl;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic                mode;
  logic [3:0]          ch_en;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                busy;
  logic                drop;
  logic                cnt_clr;
  logic [4*CNT_W-1:0]  cnt;

  always #5 clk = ~clk;

  demux4_dispatch_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .mode(mode), .ch_en(ch_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .drop(drop),
    .cnt_clr(cnt_clr), .cnt(cnt)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: one held word, its target, unready-cycle count, rr pointer, counters.
  bit          m_held = 0;
  int          m_tgt  = 0;
  int          m_rr   = 0;
  int          m_wait = 0;
  bit          m_drop = 0;
  logic [7:0]  m_data = 8'h00;
  int          m_cnt[4] = '{0, 0, 0, 0};

  task automatic model_finish();
    m_held = 0;
    if (mode) m_rr = (m_tgt + 1) % 4;
  endtask

  task automatic model_edge();
    bit rdy;
    bit found;
    rdy = !rst && !m_held && (!mode || ch_en != 4'b0000);
    if (rst) begin
      m_held = 0; m_rr = 0; m_wait = 0; m_drop = 0; m_data = 8'h00;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else begin
      m_drop = 0;
      if (m_held) begin
        if (out_ready[m_tgt]) begin
          if (m_cnt[m_tgt] < 255) m_cnt[m_tgt]++;
          model_finish();
        end else begin
          m_wait++;
          if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
            m_drop = 1;
            model_finish();
          end
        end
      end else if (in_valid && rdy) begin
        m_held = 1;
        m_data = in_data;
        m_wait = 0;
        if (!mode) m_tgt = int'(in_sel);
        else begin
          found = 0;
          for (int k = 0; k < 4; k++) begin
            if (!found && ch_en[(m_rr + k) % 4]) begin
              m_tgt = (m_rr + k) % 4;
              found = 1;
            end
          end
        end
      end
      if (cnt_clr) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end
  endtask

  task automatic compare();
    logic [31:0] exp_cnt;
    for (int k = 0; k < 4; k++) exp_cnt[k*8 +: 8] = 8'(m_cnt[k]);
    check("in_ready", in_ready, !rst && !m_held && (!mode || ch_en != 4'b0000));
    check("busy", busy, m_held);
    check("out_valid", out_valid, m_held ? 64'(1 << m_tgt) : 64'd0);
    check("drop", drop, m_drop);
    if (m_held) check("out_data", out_data, m_data);
    check("cnt", cnt, exp_cnt);
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [3:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  int         c1;
  int         ready_pct;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 2'd0; mode = 1'b0;
    ch_en = 4'b0000; out_ready = 4'b0000; cnt_clr = 1'b0;
    @(posedge clk); #1;
    step(); step();
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    step();

    // Explicit select, immediate delivery.
    mode = 1'b0; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'hF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 4'b0100);
    check("t1_data", out_data, 8'hA5);
    step();
    check("t1_cnt2", cnt[16 +: 8], 8'd1);
    check("t1_ready", in_ready, 1'b1);

    // Round-robin over channels 0,1,3.
    mode = 1'b1; ch_en = 4'b1011;
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1; in_data = 8'hD0 + 8'(w);
      step();
      in_valid = 1'b0;
      check("t2_route", out_valid, rr_exp[w]);
      step();
    end

    // Timeout with drop.
    mode = 1'b0; in_sel = 2'd1; out_ready = 4'b0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    c1 = m_cnt[1];
    repeat (16) step();
    check("t3_drop", drop, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_cnt1", cnt[8 +: 8], 8'(c1));
    step();
    check("t3_drop_pulse", drop, 1'b0);

    // Delivery on the final wait cycle beats the timeout.
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    out_ready = 4'b0010;
    step();
    check("t4_drop", drop, 1'b0);
    check("t4_cnt1", cnt[8 +: 8], 8'(c1 + 1));

    // Saturation, then clear coincident with a delivery.
    in_sel = 2'd3; out_ready = 4'hF;
    repeat (256) begin
      in_valid = 1'b1; step();
      in_valid = 1'b0; step();
    end
    check("t5_sat", cnt[24 +: 8], 8'hFF);
    in_valid = 1'b1; step();
    in_valid = 1'b0; cnt_clr = 1'b1; step();
    cnt_clr = 1'b0;
    check("t5_clr", cnt[24 +: 8], 8'h00);

    // Reset while busy.
    in_sel = 2'd0; out_ready = 4'b0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t6_valid", out_valid, 4'b0000);
    check("t6_busy", busy, 1'b0);
    check("t6_drop", drop, 1'b0);
    check("t6_cnt", cnt, 32'd0);
    check("t6_ready", in_ready, 1'b0);
    rst = 1'b0;
    step();

    // Randomized traffic with varying downstream readiness.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ready_pct = $urandom_range(5, 90);
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sel    = 2'($urandom);
      mode      = 1'($urandom);
      ch_en     = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
      for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 99) < ready_pct);
      cnt_clr   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
